// File: rtl/ldst_arbiter.sv
// Two-requester arbiter in front of the single-outstanding ldst switch port.
// Fixed priority (m0 first) by default; define LDST_ARB_RR_EN for round-robin tie-breaking.
package ldst_types_pkg;
  typedef logic [31:0] ptr;
  typedef logic [31:0] word;
endpackage

module ldst_arbiter
  import ldst_types_pkg::*;
(
  input  logic clk,
  input  logic rst_n,

  input  logic m0_start,
  input  logic m0_write,
  input  ptr   m0_addr,
  input  word  m0_data_wr,
  output logic m0_ready,
  output word  m0_data_rd,

  input  logic m1_start,
  input  logic m1_write,
  input  ptr   m1_addr,
  input  word  m1_data_wr,
  output logic m1_ready,
  output word  m1_data_rd,

  output logic ldst_start,
  output logic ldst_write,
  output ptr   ldst_addr,
  output word  ldst_data_wr,
  input  logic ldst_ready,
  input  word  ldst_data_rd
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   last_q, last_d;

  logic acc_open;
  logic e0, e1;
  logic win1;
  logic grant;
  logic sel1;

  always_comb begin
    acc_open = (owner_q == IDLE) || ldst_ready;
    // The completing owner still holds start this cycle; don't re-grant it.
    e0 = m0_start && !((owner_q == M0) && ldst_ready);
    e1 = m1_start && !((owner_q == M1) && ldst_ready);
`ifdef LDST_ARB_RR_EN
    win1 = (e0 && e1) ? !last_q : e1;
`else
    win1 = !e0 && e1;
`endif
    grant = acc_open && (e0 || e1);
    sel1  = grant ? win1 : (owner_q == M1);

    owner_d = owner_q;
    last_d  = last_q;
    if (acc_open) begin
      if (grant) begin
        last_d = win1;
        if (win1) begin
          owner_d = M1;
        end else begin
          owner_d = M0;
        end
      end else begin
        owner_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Gate the issue strobe so nothing leaks out while the requesters are held in reset.
  assign ldst_start   = rst_n && grant;
  assign ldst_write   = sel1 ? m1_write   : m0_write;
  assign ldst_addr    = sel1 ? m1_addr    : m0_addr;
  assign ldst_data_wr = sel1 ? m1_data_wr : m0_data_wr;

  assign m0_ready   = ldst_ready && (owner_q == M0);
  assign m1_ready   = ldst_ready && (owner_q == M1);
  assign m0_data_rd = ldst_data_rd;
  assign m1_data_rd = ldst_data_rd;

endmodule

// File: tb/tb_ldst_arbiter.sv
// Directed, table-driven bench for ldst_arbiter; expectations follow LDST_ARB_RR_EN.
module tb_ldst_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_start, m0_write, m0_ready;
  logic [31:0] m0_addr, m0_data_wr, m0_data_rd;
  logic        m1_start, m1_write, m1_ready;
  logic [31:0] m1_addr, m1_data_wr, m1_data_rd;
  logic        ldst_start, ldst_write, ldst_ready;
  logic [31:0] ldst_addr, ldst_data_wr, ldst_data_rd;

  ldst_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_start     (m0_start),
    .m0_write     (m0_write),
    .m0_addr      (m0_addr),
    .m0_data_wr   (m0_data_wr),
    .m0_ready     (m0_ready),
    .m0_data_rd   (m0_data_rd),
    .m1_start     (m1_start),
    .m1_write     (m1_write),
    .m1_addr      (m1_addr),
    .m1_data_wr   (m1_data_wr),
    .m1_ready     (m1_ready),
    .m1_data_rd   (m1_data_rd),
    .ldst_start   (ldst_start),
    .ldst_write   (ldst_write),
    .ldst_addr    (ldst_addr),
    .ldst_data_wr (ldst_data_wr),
    .ldst_ready   (ldst_ready),
    .ldst_data_rd (ldst_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LDST_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct {
    logic        rst;
    logic        m0s, m0w;
    logic [31:0] m0a, m0d;
    logic        m1s, m1w;
    logic [31:0] m1a, m1d;
    logic        rdy;
    logic [31:0] rd;
    logic        es, ew;
    logic [31:0] ea, ed;
    logic        er0, er1;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(input logic rst, input logic m0s, input logic m0w,
                              input logic [31:0] m0a, input logic [31:0] m0d,
                              input logic m1s, input logic m1w,
                              input logic [31:0] m1a, input logic [31:0] m1d,
                              input logic rdy, input logic [31:0] rd,
                              input logic es, input logic ew,
                              input logic [31:0] ea, input logic [31:0] ed,
                              input logic er0, input logic er1);
    vec_t v;
    v.rst = rst; v.m0s = m0s; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
    v.m1s = m1s; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
    v.rdy = rdy; v.rd = rd;
    v.es = es; v.ew = ew; v.ea = ea; v.ed = ed; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  function automatic vec_t idle_row(input logic rst);
    return mk(rst, L, L, Z, Z, L, L, Z, Z, L, Z, L, L, Z, Z, L, L);
  endfunction

  task automatic apply(input vec_t v);
    rst_n        = !v.rst;
    m0_start     = v.m0s;
    m0_write     = v.m0w;
    m0_addr      = v.m0a;
    m0_data_wr   = v.m0d;
    m1_start     = v.m1s;
    m1_write     = v.m1w;
    m1_addr      = v.m1a;
    m1_data_wr   = v.m1d;
    ldst_ready   = v.rdy;
    ldst_data_rd = v.rd;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
    else begin
      passes++;
      $display("chk %s ok (%h)", nm, act);
    end
  endtask

  initial begin
    // Initial reset with a request already pending: nothing may issue.
    rst_n = 1'b0;
    m0_start = 1'b1; m0_write = 1'b0; m0_addr = 32'h0; m0_data_wr = 32'h0;
    m1_start = 1'b0; m1_write = 1'b0; m1_addr = 32'h0; m1_data_wr = 32'h0;
    ldst_ready = 1'b1; ldst_data_rd = 32'h0;
    #12;
    chk("rst_start", {31'b0, ldst_start}, 32'd0);
    chk("rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    m0_start = 1'b0;
    ldst_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single load, switch answers 3 cycles after issue.
    vecs.push_back(idle_row(H));
    vecs.push_back(mk(L, H, L, 32'h100, 32'hAAAA0000, L, L, Z, Z, L, Z, H, L, 32'h100, 32'hAAAA0000, L, L));
    vecs.push_back(mk(L, H, L, 32'h100, 32'hAAAA0000, L, L, Z, Z, L, Z, L, L, 32'h100, 32'hAAAA0000, L, L));
    vecs.push_back(mk(L, H, L, 32'h100, 32'hAAAA0000, L, L, Z, Z, L, Z, L, L, 32'h100, 32'hAAAA0000, L, L));
    vecs.push_back(mk(L, H, L, 32'h100, 32'hAAAA0000, L, L, Z, Z, H, 32'hDEADBEEF, L, L, 32'h100, 32'hAAAA0000, H, L));
    vecs.push_back(idle_row(L));
    // Simultaneous requests after reset: m0 first, m1 hands off in m0's ready cycle.
    vecs.push_back(idle_row(H));
    vecs.push_back(mk(L, H, L, 32'h10, Z, H, H, 32'h08000000, 32'h12345678, L, Z, H, L, 32'h10, Z, L, L));
    vecs.push_back(mk(L, H, L, 32'h10, Z, H, H, 32'h08000000, 32'h12345678, L, Z, L, L, 32'h10, Z, L, L));
    vecs.push_back(mk(L, H, L, 32'h10, Z, H, H, 32'h08000000, 32'h12345678, H, 32'hCAFEF00D, H, H, 32'h08000000, 32'h12345678, H, L));
    vecs.push_back(mk(L, L, L, Z, Z, H, H, 32'h08000000, 32'h12345678, L, Z, L, H, 32'h08000000, 32'h12345678, L, L));
    vecs.push_back(mk(L, L, L, Z, Z, H, H, 32'h08000000, 32'h12345678, H, 32'h11112222, L, H, 32'h08000000, 32'h12345678, L, H));
    vecs.push_back(idle_row(L));
    // Back-to-back m1: one idle cycle between m1_ready and the next issue.
    vecs.push_back(mk(L, L, L, Z, Z, H, L, 32'h200, 32'h55, L, Z, H, L, 32'h200, 32'h55, L, L));
    vecs.push_back(mk(L, L, L, Z, Z, H, L, 32'h200, 32'h55, H, 32'h0A0B0C0D, L, L, 32'h200, 32'h55, L, H));
    vecs.push_back(idle_row(L));
    vecs.push_back(mk(L, L, L, Z, Z, H, L, 32'h204, 32'h66, L, Z, H, L, 32'h204, 32'h66, L, L));
    vecs.push_back(mk(L, L, L, Z, Z, H, L, 32'h204, 32'h66, H, 32'h1, L, L, 32'h204, 32'h66, L, H));
    vecs.push_back(idle_row(L));
    // Stray ready while idle.
    vecs.push_back(mk(L, L, L, Z, Z, L, L, Z, Z, H, 32'h77777777, L, L, Z, Z, L, L));
    vecs.push_back(idle_row(L));
    // Tie in IDLE after m0 was last granted: round-robin picks m1, fixed priority picks m0.
    vecs.push_back(mk(L, H, H, 32'h500, 32'hABCD, L, L, Z, Z, L, Z, H, H, 32'h500, 32'hABCD, L, L));
    vecs.push_back(mk(L, H, H, 32'h500, 32'hABCD, L, L, Z, Z, H, Z, L, H, 32'h500, 32'hABCD, H, L));
    vecs.push_back(idle_row(L));
    vecs.push_back(mk(L, H, L, 32'h600, Z, H, H, 32'h700, 32'hBEEF, L, Z,
                      H, RR ? H : L, RR ? 32'h700 : 32'h600, RR ? 32'hBEEF : Z, L, L));
    vecs.push_back(mk(L, H, L, 32'h600, Z, H, H, 32'h700, 32'hBEEF, H, 32'h3,
                      H, RR ? L : H, RR ? 32'h600 : 32'h700, RR ? Z : 32'hBEEF, RR ? L : H, RR ? H : L));
    vecs.push_back(mk(L, RR ? H : L, L, 32'h600, Z, RR ? L : H, H, 32'h700, 32'hBEEF, H, 32'h4,
                      L, RR ? L : H, RR ? 32'h600 : 32'h700, RR ? Z : 32'hBEEF, RR ? H : L, RR ? L : H));
    vecs.push_back(idle_row(L));
    // Contention: both hold start, switch answers next cycle; six grants alternate.
    vecs.push_back(idle_row(H));
    vecs.push_back(mk(L, H, L, 32'h1000, 32'h1, H, H, 32'h2000, 32'h2, L, Z, H, L, 32'h1000, 32'h1, L, L));
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0)
        vecs.push_back(mk(L, H, L, 32'h1000, 32'h1, H, H, 32'h2000, 32'h2, H, 32'h100 + k, H, H, 32'h2000, 32'h2, H, L));
      else
        vecs.push_back(mk(L, H, L, 32'h1000, 32'h1, H, H, 32'h2000, 32'h2, H, 32'h100 + k, H, L, 32'h1000, 32'h1, L, H));
    end
    vecs.push_back(mk(L, L, L, 32'h1000, 32'h1, H, H, 32'h2000, 32'h2, H, 32'h200, L, H, 32'h2000, 32'h2, L, H));
    vecs.push_back(idle_row(L));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1 apply(v);
      @(negedge clk);
      checks++;
      if ({ldst_start, ldst_write, ldst_addr, ldst_data_wr, m0_ready, m1_ready, m0_data_rd, m1_data_rd} !==
          {v.es, v.ew, v.ea, v.ed, v.er0, v.er1, v.rd, v.rd}) begin
        $display("FAIL vec%0d: got start=%b wr=%b addr=%h dwr=%h r0=%b r1=%b rd0=%h rd1=%h, want start=%b wr=%b addr=%h dwr=%h r0=%b r1=%b rd=%h",
                 i, ldst_start, ldst_write, ldst_addr, ldst_data_wr, m0_ready, m1_ready, m0_data_rd, m1_data_rd,
                 v.es, v.ew, v.ea, v.ed, v.er0, v.er1, v.rd);
      end else begin
        passes++;
        $display("vec%0d ok: start=%b addr=%h r0=%b r1=%b", i, ldst_start, ldst_addr, m0_ready, m1_ready);
      end
    end

    // Reset mid-transaction: outputs drop at once, pending m1 issues right after release.
    @(posedge clk); #1;
    m0_start = 1'b1; m0_write = 1'b0; m0_addr = 32'h300; m0_data_wr = 32'h0;
    @(negedge clk);
    chk("mid_issue", {31'b0, ldst_start}, 32'd1);
    @(posedge clk); #1;
    m1_start = 1'b1; m1_write = 1'b1; m1_addr = 32'h400; m1_data_wr = 32'h99;
    @(negedge clk);
    chk("mid_busy_start", {31'b0, ldst_start}, 32'd0);
    chk("mid_busy_addr", ldst_addr, 32'h300);
    @(posedge clk); #3;
    rst_n = 1'b0;
    m0_start = 1'b0;
    ldst_ready = 1'b1;
    #1;
    chk("mid_rst_start", {31'b0, ldst_start}, 32'd0);
    chk("mid_rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("mid_rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ldst_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_start", {31'b0, ldst_start}, 32'd1);
    chk("post_rst_addr", ldst_addr, 32'h400);
    chk("post_rst_data", ldst_data_wr, 32'h99);
    @(posedge clk); #1;
    ldst_ready = 1'b1;
    ldst_data_rd = 32'h4242;
    @(negedge clk);
    chk("post_rst_m1_ready", {31'b0, m1_ready}, 32'd1);
    chk("post_rst_m0_ready", {31'b0, m0_ready}, 32'd0);
    chk("post_rst_no_reissue", {31'b0, ldst_start}, 32'd0);
    chk("post_rst_rd", m1_data_rd, 32'h4242);
    @(posedge clk); #1;
    m1_start = 1'b0;
    ldst_ready = 1'b0;
    @(posedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
